// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one 16-bit word from an upstream
// synchronous FIFO and sends it as two back-to-back 8N1 frames,
// high byte first. Every output is registered.
module fifo_uart_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic        clk,
    input  logic        sclr,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_q,
    output logic        fifo_rdreq,
    output logic        uart_tx,
    output logic        busy,
    output logic        tx_done
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [4:0]       BIT_LAST  = 5'd19;

    typedef enum logic [2:0] {IDLE, RD, LD, TX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [4:0]       bit_q, bit_d;
    logic [15:0]      hold_q, hold_d;
    logic             tx_q, tx_d;
    logic             rdreq_q, rdreq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Line level for bit idx (0..19) of the two-frame word:
    // idx 0..9 carry the high byte, 10..19 the low byte.
    function automatic logic frame_bit(input logic [15:0] w, input logic [4:0] idx);
        logic [7:0] data;
        logic [4:0] pos;
        if (idx >= 5'd10) begin
            data = w[7:0];
            pos  = idx - 5'd10;
        end else begin
            data = w[15:8];
            pos  = idx;
        end
        if (pos == 5'd0) begin
            frame_bit = 1'b0;                   // start bit
        end else if (pos >= 5'd9) begin
            frame_bit = 1'b1;                   // stop bit
        end else begin
            frame_bit = data[3'(pos - 5'd1)];   // data, LSB first
        end
    endfunction

    // Next-state logic; outputs are derived from the next state so they
    // can be registered alongside it.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: if (!fifo_empty) state_d = RD;
            RD:   state_d = LD;
            LD: begin
                // FIFO data is valid during LD (one cycle after rdreq)
                hold_d  = fifo_q;
                baud_d  = '0;
                bit_d   = '0;
                state_d = TX;
            end
            TX: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdreq_d = (state_d == RD);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        tx_d    = (state_d == TX) ? frame_bit(hold_d, bit_d) : 1'b1;
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
            rdreq_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            rdreq_q <= rdreq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rdreq = rdreq_q;
    assign uart_tx    = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at BAUD_DIV = 4: FIFO model, per-cycle word-level
// output model, UART byte decoder, and directed scenarios.
module tb_fifo_uart_tx;

    localparam int DIV    = 4;
    localparam int PERIOD = 20 * DIV + 4;

    logic        clk = 1'b0;
    logic        sclr;
    logic        fifo_empty;
    logic [15:0] fifo_q;
    logic        fifo_rdreq, uart_tx, busy, tx_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (250_000)
    ) dut (
        .clk       (clk),
        .sclr      (sclr),
        .fifo_empty(fifo_empty),
        .fifo_q    (fifo_q),
        .fifo_rdreq(fifo_rdreq),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic check_en = 1'b0;

    // Upstream FIFO model, normal mode: q updates on the edge ending the rdreq cycle.
    logic [15:0] mem [0:1023];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic block_empty = 1'b0;
    assign fifo_empty = (rd_ptr == wr_ptr) || block_empty;

    always @(posedge clk) begin
        if (fifo_rdreq && rd_ptr != wr_ptr) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Word-level model: pos = cycle within a word (1 RD, 2 LD, 3.. TX, last DONE).
    int          pos = -1;
    logic [15:0] mword = '0;
    always @(posedge clk) begin
        if (sclr) begin
            pos <= -1;
        end else if (pos < 0) begin
            if (!fifo_empty) begin
                pos   <= 1;
                mword <= mem[rd_ptr];
            end
        end else if (pos == PERIOD - 1) begin
            pos <= -1;
        end else begin
            pos <= pos + 1;
        end
    end

    // Logs and decoder state
    logic     tx_at   [0:65535];
    logic     busy_at [0:65535];
    int       rd_times[$];
    int       done_times[$];
    logic [7:0] bytes_q[$];
    logic [7:0] exp_bytes[$];
    int       dcnt = -1;
    logic [7:0] dbyte;
    logic [19:0] fr;
    logic [3:0]  exp_o, act_o;

    // Per-cycle compare against the model, plus logging and UART decoding.
    always @(negedge clk) begin
        if (check_en) begin
            fr = {1'b1, mword[7:0], 1'b0, 1'b1, mword[15:8], 1'b0};
            if (pos < 0)                exp_o = 4'b0001;
            else if (pos == 1)          exp_o = 4'b1101;
            else if (pos == 2)          exp_o = 4'b0101;
            else if (pos == PERIOD - 1) exp_o = 4'b0111;
            else                        exp_o = {3'b010, fr[(pos - 3) / DIV]};
            act_o = {fifo_rdreq, busy, tx_done, uart_tx};
            tests++;
            if (act_o !== exp_o) begin
                fails++;
                $display("FAIL cycle_model cyc=%0d rdreq/busy/done/tx got %b expected %b",
                         cyc, act_o, exp_o);
            end
            tx_at[cyc]   = uart_tx;
            busy_at[cyc] = busy;
            if (fifo_rdreq) rd_times.push_back(cyc);
            if (tx_done) done_times.push_back(cyc);

            if (!busy) begin
                dcnt = -1;
            end else if (dcnt < 0) begin
                if (!uart_tx) dcnt = 0;
            end else begin
                dcnt++;
                if (dcnt % DIV == DIV / 2) begin
                    if (dcnt / DIV <= 8) begin
                        dbyte[dcnt / DIV - 1] = uart_tx;
                    end else begin
                        tests++;
                        if (uart_tx !== 1'b1) begin
                            fails++;
                            $display("FAIL stop_bit cyc=%0d got %b expected 1", cyc, uart_tx);
                        end
                        bytes_q.push_back(dbyte);
                        dcnt = -1;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1;
    endtask

    task automatic wait_rd(input int target, input int budget);
        int b = budget;
        while (rd_times.size() < target && b > 0) begin
            step(1);
            b--;
        end
        check("rdreq_timeout_rdcount", rd_times.size() >= target, 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int b = budget;
        while (done_times.size() < target && b > 0) begin
            step(1);
            b--;
        end
        check("tx_done_timeout_donecount", done_times.size() >= target, 1);
    endtask

    initial begin
        int r, s, n, nd, nbad, rel, base_rd, base_done;
        logic [0:19] a55a_bits;
        a55a_bits = 20'b01010010110010110101;  // A5 frame then 5A frame, LSB first

        // Reset
        sclr = 1'b1;
        step(3);
        check_en = 1'b1;
        step(1);
        check("reset_rdreq", fifo_rdreq, 0);
        check("reset_busy", busy, 0);
        check("reset_done", tx_done, 0);
        check("reset_tx", uart_tx, 1);

        // Empty FIFO for 50 cycles
        sclr = 1'b0;
        step(50);
        check("idle_rdreq_count", rd_times.size(), 0);
        check("idle_done_count", done_times.size(), 0);
        check("idle_busy", busy, 0);

        // Single word A55A
        push(16'hA55A);
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h5A);
        wait_done(1, 200);
        step(3);
        check("a55a_rdreq_count", rd_times.size(), 1);
        if (rd_times.size() >= 1 && done_times.size() >= 1) begin
            r = rd_times[0];
            check("a55a_done_after_start", done_times[0] - (r + 2), 80);
            check("a55a_tx_in_ld", tx_at[r + 1], 1);
            nbad = 0;
            for (int k = 0; k < 20; k++)
                for (int j = 0; j < DIV; j++)
                    if (tx_at[r + 2 + k * DIV + j] !== a55a_bits[k]) nbad++;
            check("a55a_waveform_bad_cycles", nbad, 0);
        end

        // Back-to-back stream of 0..255
        base_rd   = rd_times.size();
        base_done = done_times.size();
        for (int i = 0; i < 256; i++) begin
            push(16'(i));
            exp_bytes.push_back(8'h00);
            exp_bytes.push_back(8'(i));
        end
        wait_done(base_done + 256, 256 * PERIOD + 200);
        step(3);
        check("stream_rdreq_count", rd_times.size() - base_rd, 256);
        check("stream_done_count", done_times.size() - base_done, 256);
        nbad = 0;
        for (int i = base_rd; i + 1 < rd_times.size(); i++)
            if (rd_times[i + 1] - rd_times[i] != PERIOD) nbad++;
        check("stream_rdreq_spacing_bad", nbad, 0);

        // sclr during low-byte data bit 7 (overall bit 18)
        n  = rd_times.size();
        push(16'h1234);
        push(16'hBEEF);
        exp_bytes.push_back(8'h12);
        exp_bytes.push_back(8'hBE);
        exp_bytes.push_back(8'hEF);
        wait_rd(n + 1, 50);
        nd = done_times.size();
        r  = (rd_times.size() > n) ? rd_times[n] : cyc;
        while (cyc < r + 2 + 18 * DIV + 1) step(1);
        sclr = 1'b1;
        s    = cyc;
        step(1);
        sclr = 1'b0;
        while (cyc < s + 6) step(1);
        check("abort_tx_after", tx_at[s + 1], 1);
        check("abort_busy_after", busy_at[s + 1], 0);
        check("abort_no_done", done_times.size(), nd);
        check("abort_next_rdreq_cycle", (rd_times.size() > n + 1) ? rd_times[n + 1] : -1, s + 2);
        check("abort_tx_before_start", tx_at[s + 3], 1);
        check("abort_start_bit", tx_at[s + 4], 0);
        wait_done(nd + 1, 200);

        // No rdreq while sclr is held, even with data waiting
        step(2);
        n    = rd_times.size();
        sclr = 1'b1;
        push(16'h00C3);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'hC3);
        step(6);
        sclr = 1'b0;
        s    = cyc - 1;
        check("held_sclr_no_rdreq", rd_times.size(), n);
        step(4);
        check("held_sclr_first_rdreq", (rd_times.size() > n) ? rd_times[n] : -1, s + 2);
        wait_done(done_times.size() + 1, 200);

        // fifo_empty toggling during TX is ignored
        step(2);
        n = rd_times.size();
        push(16'h3C96);
        push(16'h0F0F);
        exp_bytes.push_back(8'h3C);
        exp_bytes.push_back(8'h96);
        exp_bytes.push_back(8'h0F);
        exp_bytes.push_back(8'h0F);
        wait_rd(n + 1, 50);
        nd = done_times.size();
        step(12);
        for (int i = 0; i < 10; i++) begin
            block_empty = ~block_empty;
            step(3);
        end
        block_empty = 1'b1;
        wait_done(nd + 1, 200);
        step(5);
        check("blocked_no_second_rdreq", rd_times.size(), n + 1);
        block_empty = 1'b0;
        rel = cyc;
        step(4);
        check("release_rdreq_cycle", (rd_times.size() > n + 1) ? rd_times[n + 1] : -1, rel + 1);
        wait_done(nd + 2, 200);
        step(10);

        // Decoded byte stream
        check("byte_count", bytes_q.size(), exp_bytes.size());
        nbad = 0;
        for (int i = 0; i < exp_bytes.size() && i < bytes_q.size(); i++) begin
            tests++;
            if (bytes_q[i] !== exp_bytes[i]) begin
                fails++;
                nbad++;
                $display("FAIL byte[%0d]: got %h expected %h", i, bytes_q[i], exp_bytes[i]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
